qbert_cube_tracker: RTL and testbench

//  Consumes the 28-bit one-hot cube-occupancy vector produced by the map/colour renderer and the move-done strobe.

---
 rtl/qbert_cube_tracker.sv | 205 ++++++++++++++++++++
 tb/tb_qbert_cube_tracker.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qbert_cube_tracker.sv
// Q*bert cube tracker: landing decode, top-colour state, scoring,
// fall-off / level-complete detection and next-jump target.
// Ports:
//   CLK_33, reset (async active-low)
//   e_start_qb, e_pause_qb, done_move, position_qb[N_CUBE], jump_dir[2]
//   color_state[N_CUBE], cube_idx[5], next_qb[N_CUBE], bad_jump,
//   ko, level_done, pos_err, score[16]
`timescale 1ns/1ps
module qbert_cube_tracker #(
  parameter int N_CUBE      = 28,
  parameter int TOGGLE_MODE = 0,
  parameter int SETTLE_CYC  = 2,
  parameter int PTS_CUBE    = 25
) (
  input  logic              CLK_33,
  input  logic              reset,
  input  logic              e_start_qb,
  input  logic              e_pause_qb,
  input  logic              done_move,
  input  logic [N_CUBE-1:0] position_qb,
  input  logic [1:0]        jump_dir,
  output logic [N_CUBE-1:0] color_state,
  output logic [4:0]        cube_idx,
  output logic [N_CUBE-1:0] next_qb,
  output logic              bad_jump,
  output logic              ko,
  output logic              level_done,
  output logic              pos_err,
  output logic [15:0]       score
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PLAY   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_KO     = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  localparam logic [7:0] SET_INIT = 8'(SETTLE_CYC - 1);
  localparam logic [N_CUBE-1:0] ONE = N_CUBE'(1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       prev_done;
  logic       pending;
  logic       rise;

  logic       pos_one;
  logic [4:0] pos_idx;

  logic [16:0] score_sum;
  logic [15:0] score_nx;

  logic [2:0] nr;
  logic [4:0] nbase;
  logic [4:0] np;
  logic [4:0] tgt;
  logic       nok;

  function automatic logic [2:0] rank_of(input logic [4:0] i);
    if (i >= 5'd21) return 3'd6;
    if (i >= 5'd15) return 3'd5;
    if (i >= 5'd10) return 3'd4;
    if (i >= 5'd6)  return 3'd3;
    if (i >= 5'd3)  return 3'd2;
    if (i >= 5'd1)  return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [4:0] base_of(input logic [2:0] r);
    logic [4:0] b;
    unique case (r)
      3'd0:    b = 5'd0;
      3'd1:    b = 5'd1;
      3'd2:    b = 5'd3;
      3'd3:    b = 5'd6;
      3'd4:    b = 5'd10;
      3'd5:    b = 5'd15;
      default: b = 5'd21;
    endcase
    return b;
  endfunction

  assign rise = done_move & ~prev_done;

  assign pos_one = (position_qb != '0) &&
    ((position_qb & (position_qb - ONE)) == '0);

  always_comb begin
    pos_idx = '0;
    for (int i = 0; i < N_CUBE; i++)
      if (position_qb[i]) pos_idx = 5'(i);
  end

  assign score_sum = {1'b0, score} + 17'(PTS_CUBE);
  assign score_nx  = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  // Neighbour index on the triangular layout: moving up a rank
  // subtracts r (or r+1), moving down adds r+1 (or r+2).
  always_comb begin
    nr    = rank_of(cube_idx);
    nbase = base_of(nr);
    np    = cube_idx - nbase;
    tgt   = '0;
    nok   = 1'b0;
    unique case (jump_dir)
      2'd0: begin
        nok = (nr != 3'd0) && (np != 5'(nr));
        tgt = cube_idx - 5'(nr);
      end
      2'd1: begin
        nok = (nr != 3'd0) && (np != 5'd0);
        tgt = cube_idx - 5'(nr) - 5'd1;
      end
      2'd2: begin
        nok = (nr != 3'd6);
        tgt = cube_idx + 5'(nr) + 5'd2;
      end
      2'd3: begin
        nok = (nr != 3'd6);
        tgt = cube_idx + 5'(nr) + 5'd1;
      end
    endcase
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      prev_done   <= 1'b0;
      pending     <= 1'b0;
      color_state <= '0;
      cube_idx    <= '0;
      next_qb     <= '0;
      bad_jump    <= 1'b1;
      ko          <= 1'b0;
      level_done  <= 1'b0;
      pos_err     <= 1'b0;
      score       <= '0;
    end else begin
      prev_done <= done_move;
      if (e_pause_qb) begin
        // Remember a landing that arrives while frozen.
        if (rise && state == S_PLAY) pending <= 1'b1;
      end else begin
        level_done <= 1'b0;
        next_qb    <= nok ? (ONE << tgt) : '0;
        bad_jump   <= ~nok;
        if (e_start_qb) begin
          // A restart after a fall keeps the painted tops.
          if (state != S_KO) color_state <= '0;
          cube_idx <= '0;
          ko       <= 1'b0;
          pos_err  <= 1'b0;
          pending  <= 1'b0;
          cnt      <= '0;
          state    <= S_PLAY;
        end else begin
          unique case (state)
            S_PLAY: begin
              if (rise || pending) begin
                state   <= S_SETTLE;
                cnt     <= SET_INIT;
                pending <= 1'b0;
              end
            end
            S_SETTLE: begin
              if (cnt == '0) state <= S_UPDATE;
              else           cnt   <= cnt - 8'd1;
            end
            S_UPDATE: begin
              if (pos_one) begin
                cube_idx <= pos_idx;
                if (TOGGLE_MODE != 0)
                  color_state[pos_idx] <= ~color_state[pos_idx];
                else
                  color_state[pos_idx] <= 1'b1;
                if (!color_state[pos_idx]) score <= score_nx;
                state <= S_CHECK;
              end else if (position_qb == '0) begin
                ko    <= 1'b1;
                state <= S_KO;
              end else begin
                pos_err <= 1'b1;
                state   <= S_PLAY;
              end
            end
            S_CHECK: begin
              if (&color_state) begin
                level_done <= 1'b1;
                state      <= S_DONE;
              end else begin
                state <= S_PLAY;
              end
            end
            S_IDLE, S_KO, S_DONE: ;
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_qbert_cube_tracker.sv
// Randomized bench for qbert_cube_tracker against a
// rule-level model of the pyramid game.
`timescale 1ns/1ps
module tb_qbert_cube_tracker;

  logic        CLK_33 = 1'b0;
  logic        reset = 1'b0;
  logic        e_start_qb = 1'b0;
  logic        e_pause_qb = 1'b0;
  logic        done_move = 1'b0;
  logic [27:0] position_qb = '0;
  logic [1:0]  jump_dir = '0;
  logic [27:0] color_state;
  logic [4:0]  cube_idx;
  logic [27:0] next_qb;
  logic        bad_jump, ko, level_done, pos_err;
  logic [15:0] score;

  logic        t_start = 1'b0;
  logic        t_done = 1'b0;
  logic [27:0] t_pos = '0;
  logic [27:0] t_color, t_next;
  logic [4:0]  t_idx;
  logic        t_bad, t_ko, t_ld, t_perr;
  logic [15:0] t_score;

  int n_vec = 0;
  int n_err = 0;

  logic [27:0] m_col;
  int          m_score, m_idx, m_st;
  logic        m_ko, m_perr;
  logic [27:0] t_mcol;
  int          t_mscore;

  always #5 CLK_33 = ~CLK_33;

  qbert_cube_tracker u_dut (
    .CLK_33(CLK_33), .reset(reset),
    .e_start_qb(e_start_qb), .e_pause_qb(e_pause_qb),
    .done_move(done_move), .position_qb(position_qb),
    .jump_dir(jump_dir), .color_state(color_state),
    .cube_idx(cube_idx), .next_qb(next_qb),
    .bad_jump(bad_jump), .ko(ko), .level_done(level_done),
    .pos_err(pos_err), .score(score)
  );

  qbert_cube_tracker #(.TOGGLE_MODE(1)) u_tog (
    .CLK_33(CLK_33), .reset(reset),
    .e_start_qb(t_start), .e_pause_qb(e_pause_qb),
    .done_move(t_done), .position_qb(t_pos),
    .jump_dir(jump_dir), .color_state(t_color),
    .cube_idx(t_idx), .next_qb(t_next),
    .bad_jump(t_bad), .ko(t_ko), .level_done(t_ld),
    .pos_err(t_perr), .score(t_score)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge CLK_33);
  endtask

  // Geometric neighbour on the pyramid, from (rank, slot).
  function automatic logic [27:0] ref_next(input int idx,
                                           input int dir);
    int r, p, nr, np;
    logic [27:0] one;
    one = 28'd1;
    r = 0;
    while ((r + 1) * (r + 2) / 2 <= idx) r++;
    p = idx - r * (r + 1) / 2;
    case (dir)
      0: begin nr = r - 1; np = p;     end
      1: begin nr = r - 1; np = p - 1; end
      2: begin nr = r + 1; np = p + 1; end
      default: begin nr = r + 1; np = p; end
    endcase
    if (nr < 0 || nr > 6 || np < 0 || np > nr) return '0;
    return one << (nr * (nr + 1) / 2 + np);
  endfunction

  task automatic m_reset();
    m_col = '0; m_score = 0; m_idx = 0; m_st = 0;
    m_ko = 0; m_perr = 0;
    t_mcol = '0; t_mscore = 0;
  endtask

  // m_st: 0 idle, 1 playing, 2 fallen, 3 level cleared
  task automatic m_apply(input logic [27:0] pos, output bit ld);
    int idx;
    ld = 0;
    if (m_st != 1) return;
    if ($countones(pos) == 1) begin
      idx = 0;
      for (int i = 0; i < 28; i++) if (pos[i]) idx = i;
      if (!m_col[idx]) begin
        m_score = m_score + 25;
        if (m_score > 65535) m_score = 65535;
      end
      m_col[idx] = 1'b1;
      m_idx = idx;
      if (m_col == '1) begin ld = 1; m_st = 3; end
    end else if (pos == '0) begin
      m_ko = 1; m_st = 2;
    end else begin
      m_perr = 1;
    end
  endtask

  task automatic check_state();
    chk("color", color_state, m_col);
    chk("idx", cube_idx, m_idx);
    chk("score", score, m_score);
    chk("ko", ko, m_ko);
    chk("pos_err", pos_err, m_perr);
  endtask

  task automatic check_next();
    logic [27:0] e;
    e = ref_next(m_idx, int'(jump_dir));
    chk("next_qb", next_qb, e);
    chk("bad_jump", bad_jump, e == '0);
  endtask

  task automatic do_start();
    e_start_qb = 1'b1;
    nclk(1);
    e_start_qb = 1'b0;
    if (m_st != 2) m_col = '0;
    m_idx = 0; m_ko = 0; m_perr = 0; m_st = 1;
    check_state();
    nclk(1);
    check_next();
  endtask

  // Entered at the negedge before the edge that sees the move.
  task automatic settle_check(input logic [27:0] pos, input bit drop);
    bit ld;
    int old_score;
    old_score = m_score;
    nclk(1);
    if (drop) done_move = 1'b0;
    nclk(2);
    chk("early_color", color_state, m_col);
    chk("early_score", score, old_score);
    m_apply(pos, ld);
    nclk(1);
    check_state();
    chk("ld_early", level_done, 0);
    nclk(1);
    chk("level_done", level_done, ld);
    check_next();
    nclk(1);
    chk("ld_pulse", level_done, 0);
  endtask

  task automatic do_move(input logic [27:0] pos);
    position_qb = pos;
    done_move = 1'b1;
    settle_check(pos, 1);
  endtask

  task automatic pause_move(input logic [27:0] pos);
    e_pause_qb = 1'b1;
    nclk(1);
    position_qb = pos;
    done_move = 1'b1;
    nclk(1);
    done_move = 1'b0;
    nclk(9);
    check_state();
    e_pause_qb = 1'b0;
    settle_check(pos, 0);
  endtask

  task automatic t_move(input logic [27:0] pos);
    int idx;
    t_pos = pos;
    t_done = 1'b1;
    nclk(1);
    t_done = 1'b0;
    nclk(4);
    idx = 0;
    for (int i = 0; i < 28; i++) if (pos[i]) idx = i;
    if (!t_mcol[idx]) t_mscore = t_mscore + 25;
    t_mcol[idx] = ~t_mcol[idx];
    chk("t_color", t_color, t_mcol);
    chk("t_score", t_score, t_mscore);
    chk("t_idx", t_idx, idx);
  endtask

  task automatic reset_check();
    chk("rst_color", color_state, 0);
    chk("rst_idx", cube_idx, 0);
    chk("rst_score", score, 0);
    chk("rst_ko", ko, 0);
    chk("rst_ld", level_done, 0);
    chk("rst_perr", pos_err, 0);
    chk("rst_next", next_qb, 0);
    chk("rst_bad", bad_jump, 1);
  endtask

  initial begin
    logic [27:0] one, pos;
    int a, b, k, off;
    one = 28'd1;
    m_reset();
    nclk(2);
    reset_check();
    reset = 1'b1;
    nclk(2);

    jump_dir = 2'd2;
    do_start();
    chk("t1_next", next_qb, 28'h0000004);
    jump_dir = 2'd0;
    nclk(1);
    chk("t1_up_next", next_qb, 0);
    chk("t1_up_bad", bad_jump, 1);

    do_move(one << 4);
    chk("t2_score", score, 25);
    do_move(one << 4);
    chk("t2_reland", score, 25);
    do_move(28'h28);
    chk("t5_perr", pos_err, 1);
    pause_move(one << 6);
    chk("t5_pause_idx", cube_idx, 6);

    for (int it = 0; it < 80; it++) begin
      if (m_st != 1) do_start();
      jump_dir = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 9);
      a = $urandom_range(0, 27);
      if (k == 0) pos = '0;
      else if (k == 1) begin
        b = (a + 1 + $urandom_range(0, 26)) % 28;
        pos = (one << a) | (one << b);
      end else pos = one << a;
      if ($urandom_range(0, 7) == 0) pause_move(pos);
      else do_move(pos);
    end

    reset = 1'b0;
    m_reset();
    nclk(1);
    reset = 1'b1;
    nclk(1);
    do_start();
    off = $urandom_range(0, 27);
    for (int i = 0; i < 28; i++) begin
      jump_dir = 2'($urandom_range(0, 3));
      do_move(one << ((i * 5 + off) % 28));
    end
    chk("t3_score", score, 700);
    do_move(one << 5);
    chk("t3_ignored", score, 700);

    do_start();
    do_move(one << 4);
    do_move('0);
    chk("t4_ko", ko, 1);
    do_start();
    chk("t4_kept", color_state, one << 4);

    position_qb = one << 7;
    done_move = 1'b1;
    nclk(1);
    done_move = 1'b0;
    #1 reset = 1'b0;
    #1;
    m_reset();
    reset_check();
    nclk(2);
    reset = 1'b1;
    nclk(4);
    check_state();

    t_start = 1'b1;
    nclk(1);
    t_start = 1'b0;
    nclk(1);
    t_move(one << 9);
    t_move(one << 9);
    chk("t6_clear", t_color[9], 0);
    t_move(one << 9);

    for (int lv = 0; lv < 95; lv++) begin
      do_start();
      off = $urandom_range(0, 27);
      for (int i = 0; i < 28; i++)
        do_move(one << ((i * 5 + off) % 28));
    end
    chk("sat_score", score, 16'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
